// File: rtl/ifu_fetch_ctrl_if.sv
// Instruction-memory request/response channel between the fetch controller (master)
// and instruction memory (slave): one valid/ready request, one response beat per request.
interface ifu_fetch_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;

  modport master (
    output req_valid,
    output req_addr,
    input  req_ready,
    input  rsp_valid,
    input  rsp_data
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    output req_ready,
    output rsp_valid,
    output rsp_data
  );
endinterface

// File: rtl/ifu_fetch_ctrl.sv
// Fetch front end: owns the PC, keeps one imem request in flight and presents {if_pc, if_instr}.
// Define IFU_MISALIGN_CHECK_EN to turn misaligned redirect targets into a held fault output.
module ifu_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             redirect,
  input  logic [31:0]      redirect_pc,
  ifu_fetch_ctrl_if.master imem,
  output logic             if_valid,
  output logic [31:0]      if_pc,
  output logic [31:0]      if_instr,
  output logic             if_misalign
);

  localparam logic [2:0] S_REQ  = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [2:0] S_HOLD = 3'd2;
  localparam logic [2:0] S_DROP = 3'd3;
`ifdef IFU_MISALIGN_CHECK_EN
  localparam logic [2:0] S_FAULT = 3'd4;
`endif

  logic [2:0]  state;
  logic [31:0] pc;
  logic        handshake;
  logic        consume;
  logic        stale_after;
  logic [31:0] redirect_target;

  assign imem.req_valid = (state == S_REQ) & ~rst;
  assign imem.req_addr  = pc;
  assign handshake      = imem.req_valid & imem.req_ready;
  assign consume        = if_valid & ~stall;

  // A request is still owed a response after this edge if one is accepted now,
  // or one is in flight and its response is not arriving this cycle.
  assign stale_after = ((state == S_REQ) & handshake)
                     | (((state == S_WAIT) | (state == S_DROP)) & ~imem.rsp_valid);

`ifdef IFU_MISALIGN_CHECK_EN
  logic fault_pend;
  logic target_misaligned;

  assign redirect_target   = redirect_pc;
  assign target_misaligned = |redirect_pc[1:0];
`else
  assign redirect_target = redirect_pc & 32'hFFFF_FFFC;
  assign if_misalign     = 1'b0;
`endif

  // NOTE: all state below uses non-blocking assignments so every register samples
  // pre-edge values; a later assignment in the same block simply takes priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_REQ;
      pc       <= RESET_PC;
      if_valid <= 1'b0;
      if_pc    <= '0;
      if_instr <= '0;
`ifdef IFU_MISALIGN_CHECK_EN
      if_misalign <= 1'b0;
      fault_pend  <= 1'b0;
`endif
    end else if (redirect) begin
      pc       <= redirect_target;
      if_valid <= 1'b0;
      state    <= stale_after ? S_DROP : S_REQ;
`ifdef IFU_MISALIGN_CHECK_EN
      if_misalign <= 1'b0;
      fault_pend  <= target_misaligned & stale_after;
      if (target_misaligned & ~stale_after) begin
        state       <= S_FAULT;
        if_valid    <= 1'b1;
        if_pc       <= redirect_pc;
        if_instr    <= '0;
        if_misalign <= 1'b1;
      end
`endif
    end else begin
      case (state)
        S_REQ: begin
          if (handshake) state <= S_WAIT;
        end
        S_WAIT: begin
          if (imem.rsp_valid) begin
            if_pc    <= pc;
            if_instr <= imem.rsp_data;
            if_valid <= 1'b1;
            pc       <= pc + 32'd4;
            state    <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (consume) begin
            if_valid <= 1'b0;
            state    <= S_REQ;
          end
        end
        S_DROP: begin
          if (imem.rsp_valid) begin
`ifdef IFU_MISALIGN_CHECK_EN
            // The drained fetch was hiding a misaligned redirect; raise the fault now.
            if (fault_pend) begin
              state       <= S_FAULT;
              if_valid    <= 1'b1;
              if_pc       <= pc;
              if_instr    <= '0;
              if_misalign <= 1'b1;
              fault_pend  <= 1'b0;
            end else
`endif
            state <= S_REQ;
          end
        end
`ifdef IFU_MISALIGN_CHECK_EN
        S_FAULT: begin
          state <= S_FAULT;
        end
`endif
        default: state <= S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Directed bench for ifu_fetch_ctrl: an imem responder, a transaction-level model of the
// fetch front end compared every negedge, and hand-computed literal checks per scenario.
module tb_ifu_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_misalign;

  ifu_fetch_ctrl_if bus ();

  ifu_fetch_ctrl #(.RESET_PC(32'h8000_0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem        (bus),
    .if_valid    (if_valid),
    .if_pc       (if_pc),
    .if_instr    (if_instr),
    .if_misalign (if_misalign)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  // ---------------- imem responder ----------------
  int          lat      = 1;
  logic        force_en = 1'b0;
  logic [31:0] force_val = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ~a;
  endfunction

  initial begin
    logic [31:0] data;
    bus.rsp_valid = 1'b0;
    bus.rsp_data  = '0;
    forever begin
      @(posedge clk);
      if (!rst && bus.req_valid && bus.req_ready) begin
        data = force_en ? force_val : mem_word(bus.req_addr);
        repeat (lat - 1) @(posedge clk);
        #2;
        bus.rsp_valid = 1'b1;
        bus.rsp_data  = data;
        @(posedge clk);
        #2;
        bus.rsp_valid = 1'b0;
      end
    end
  end

  // ---------------- transaction-level model ----------------
  logic [31:0] m_pc    = 32'h8000_0000;
  bit          m_out   = 0;   // a request is owed a response
  bit          m_stale = 0;   // that response must be thrown away
  bit          m_held  = 0;   // an unconsumed instruction is presented
  bit          m_fault = 0;
  bit          m_pend  = 0;   // fault waits for a stale response to drain
  bit          m_valid = 0;
  logic [31:0] m_ipc   = '0;
  logic [31:0] m_instr = '0;
  bit          m_mis   = 0;

  task automatic m_enter_fault();
    m_fault = 1; m_valid = 1; m_ipc = m_pc; m_instr = '0; m_mis = 1; m_pend = 0;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pc = 32'h8000_0000; m_out = 0; m_stale = 0; m_held = 0; m_fault = 0; m_pend = 0;
      m_valid = 0; m_ipc = '0; m_instr = '0; m_mis = 0;
    end else begin
      bit req_v, hs, rsp_here, out_after;
      req_v     = !m_out && !m_held && !m_fault;
      hs        = req_v && bus.req_ready;
      rsp_here  = m_out && bus.rsp_valid;
      out_after = hs || (m_out && !bus.rsp_valid);
      if (redirect) begin
        m_valid = 0; m_held = 0; m_fault = 0; m_mis = 0; m_pend = 0;
        m_out = out_after; m_stale = out_after;
`ifdef IFU_MISALIGN_CHECK_EN
        m_pc = redirect_pc;
        if (redirect_pc[1:0] != 2'b00) begin
          if (out_after) m_pend = 1;
          else m_enter_fault();
        end
`else
        m_pc = {redirect_pc[31:2], 2'b00};
`endif
      end else if (rsp_here) begin
        m_out = 0;
        if (m_stale) begin
          m_stale = 0;
          if (m_pend) m_enter_fault();
        end else begin
          m_valid = 1; m_held = 1; m_ipc = m_pc; m_instr = bus.rsp_data; m_pc = m_pc + 32'd4;
        end
      end else if (hs) begin
        m_out = 1;
      end else if (m_held && !stall) begin
        m_held = 0; m_valid = 0;
      end
    end
  end

  always @(negedge clk) begin
    logic exp_req;
    exp_req = !rst && !m_out && !m_held && !m_fault;
    check("model_req_valid", {31'b0, bus.req_valid}, {31'b0, exp_req});
    if (exp_req) check("model_req_addr", bus.req_addr, m_pc);
    check("model_if_valid", {31'b0, if_valid}, {31'b0, m_valid});
    check("model_if_pc", if_pc, m_ipc);
    check("model_if_instr", if_instr, m_instr);
    check("model_if_misalign", {31'b0, if_misalign}, {31'b0, m_mis});
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_valid(output int steps);
    steps = 0;
    do begin
      step();
      steps++;
    end while (!if_valid && steps < 40);
    if (!if_valid) timeout("wait_valid");
  endtask

  task automatic wait_req();
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!bus.req_valid && n < 40);
    if (!bus.req_valid) timeout("wait_req");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0; bus.req_ready = 1'b1;

    // Reset state
    step();
    check("rst_req_valid", {31'b0, bus.req_valid}, 32'd0);
    check("rst_req_addr", bus.req_addr, 32'h8000_0000);
    check("rst_if_valid", {31'b0, if_valid}, 32'd0);
    check("rst_if_pc", if_pc, 32'd0);
    check("rst_if_instr", if_instr, 32'd0);
    check("rst_if_misalign", {31'b0, if_misalign}, 32'd0);
    step();
    rst = 1'b0;

    // 1: back-to-back fetches, one every 3 cycles
    wait_valid(s);
    check("t1_pc0", if_pc, 32'h8000_0000);
    check("t1_instr0", if_instr, 32'h7FFF_FFFF);
    wait_valid(s);
    check("t1_gap1", s, 32'd3);
    check("t1_pc1", if_pc, 32'h8000_0004);
    wait_valid(s);
    check("t1_gap2", s, 32'd3);
    check("t1_pc2", if_pc, 32'h8000_0008);

    // 2: stall holds the presented instruction and blocks new requests
    step();
    stall = 1'b1; force_en = 1'b1; force_val = 32'h0010_0093;
    wait_valid(s);
    force_en = 1'b0;
    check("t2_instr", if_instr, 32'h0010_0093);
    check("t2_pc", if_pc, 32'h8000_000C);
    for (int i = 0; i < 4; i++) begin
      step();
      check("t2_hold_valid", {31'b0, if_valid}, 32'd1);
      check("t2_hold_pc", if_pc, 32'h8000_000C);
      check("t2_hold_instr", if_instr, 32'h0010_0093);
      check("t2_no_req", {31'b0, bus.req_valid}, 32'd0);
    end
    stall = 1'b0;
    step();
    check("t2_req_after", {31'b0, bus.req_valid}, 32'd1);
    check("t2_addr_after", bus.req_addr, 32'h8000_0010);

    // 3: redirect during WAIT; stale DEADBEEF is drained, never presented
    lat = 3; force_en = 1'b1; force_val = 32'hDEAD_BEEF;
    step();
    force_en = 1'b0;
    redirect = 1'b1; redirect_pc = 32'h8000_0100;
    step();
    redirect = 1'b0;
    check("t3_drop_noreq0", {31'b0, bus.req_valid}, 32'd0);
    step();
    check("t3_drop_noreq1", {31'b0, bus.req_valid}, 32'd0);
    step();
    check("t3_req", {31'b0, bus.req_valid}, 32'd1);
    check("t3_addr", bus.req_addr, 32'h8000_0100);
    lat = 1;
    wait_valid(s);
    check("t3_pc", if_pc, 32'h8000_0100);
    check("t3_instr", if_instr, 32'h7FFF_FEFF);

    // 4a: redirect together with the response in WAIT -> straight back to REQ
    lat = 2;
    wait_req();
    step();
    step();
    redirect = 1'b1; redirect_pc = 32'h8000_0200;
    step();
    redirect = 1'b0;
    check("t4a_req", {31'b0, bus.req_valid}, 32'd1);
    check("t4a_addr", bus.req_addr, 32'h8000_0200);
    check("t4a_if_valid", {31'b0, if_valid}, 32'd0);

    // 4b: redirect together with the request handshake -> one response drained
    redirect = 1'b1; redirect_pc = 32'h8000_0300;
    step();
    redirect = 1'b0;
    check("t4b_drop0", {31'b0, bus.req_valid}, 32'd0);
    step();
    check("t4b_drop1", {31'b0, bus.req_valid}, 32'd0);
    step();
    check("t4b_req", {31'b0, bus.req_valid}, 32'd1);
    check("t4b_addr", bus.req_addr, 32'h8000_0300);
    wait_valid(s);
    check("t4b_pc", if_pc, 32'h8000_0300);

    // 5: PC wraps past FFFF_FFFC
    lat = 1;
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0;
    check("t5_addr", bus.req_addr, 32'hFFFF_FFFC);
    wait_valid(s);
    check("t5_pc", if_pc, 32'hFFFF_FFFC);
    step();
    check("t5_req_wrap", {31'b0, bus.req_valid}, 32'd1);
    check("t5_addr_wrap", bus.req_addr, 32'h0000_0000);
    wait_valid(s);
    check("t5_pc_wrap", if_pc, 32'h0000_0000);

    // 6: misaligned redirect target
    redirect = 1'b1; redirect_pc = 32'h8000_0102;
    step();
    redirect = 1'b0;
`ifdef IFU_MISALIGN_CHECK_EN
    for (int i = 0; i < 3; i++) begin
      check("t6_fault_valid", {31'b0, if_valid}, 32'd1);
      check("t6_fault_pc", if_pc, 32'h8000_0102);
      check("t6_fault_instr", if_instr, 32'd0);
      check("t6_fault_mis", {31'b0, if_misalign}, 32'd1);
      check("t6_fault_noreq", {31'b0, bus.req_valid}, 32'd0);
      step();
    end
    redirect = 1'b1; redirect_pc = 32'h8000_0400;
    step();
    check("t6_exit_req", {31'b0, bus.req_valid}, 32'd1);
    check("t6_exit_addr", bus.req_addr, 32'h8000_0400);
    check("t6_exit_mis", {31'b0, if_misalign}, 32'd0);
    lat = 2; redirect_pc = 32'h8000_0406;
    step();
    redirect = 1'b0;
    check("t6_drain_valid", {31'b0, if_valid}, 32'd0);
    check("t6_drain_noreq", {31'b0, bus.req_valid}, 32'd0);
    step();
    step();
    check("t6_late_fault_valid", {31'b0, if_valid}, 32'd1);
    check("t6_late_fault_mis", {31'b0, if_misalign}, 32'd1);
    check("t6_late_fault_pc", if_pc, 32'h8000_0406);
    redirect = 1'b1; redirect_pc = 32'h8000_0100;
    step();
    redirect = 1'b0;
    lat = 1;
`else
    check("t6_req", {31'b0, bus.req_valid}, 32'd1);
    check("t6_addr", bus.req_addr, 32'h8000_0100);
    check("t6_mis", {31'b0, if_misalign}, 32'd0);
`endif

    // 7: reset mid-transaction; the pre-reset response is ignored
    lat = 3;
    wait_req();
    step();
    rst = 1'b1;
    #1;
    check("t7_rst_noreq", {31'b0, bus.req_valid}, 32'd0);
    check("t7_rst_if_valid", {31'b0, if_valid}, 32'd0);
    step();
    rst = 1'b0; bus.req_ready = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("t7_ignored", {31'b0, if_valid}, 32'd0);
    check("t7_req", {31'b0, bus.req_valid}, 32'd1);
    check("t7_addr", bus.req_addr, 32'h8000_0000);
    lat = 1; bus.req_ready = 1'b1;
    wait_valid(s);
    check("t7_pc", if_pc, 32'h8000_0000);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
